// File: rtl/rev_seq_pkg.sv
// rev_seq_pkg -- shared types for the reversible gate sequencer.
//   op_t    : 2-bit gate opcode (NOP, CNOT, TOFFOLI, FREDKIN)
//   instr_t : decoded instruction; bit indices are zero-extended to MAX_IW
//             bits so the struct does not depend on the register width
//   fsm_t   : sequencer states IDLE / RUN / DONE
//   idx_ok  : true when a decoded bit index addresses a real state bit
package rev_seq_pkg;

   localparam int MAX_IW = 8;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_CNOT = 2'b01,
      OP_TOFF = 2'b10,
      OP_FRED = 2'b11
   } op_t;

   typedef struct packed {
      op_t               op;
      logic [MAX_IW-1:0] c1;
      logic [MAX_IW-1:0] c2;
      logic [MAX_IW-1:0] t;
   } instr_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } fsm_t;

   function automatic logic idx_ok(input logic [MAX_IW-1:0] idx, input int width);
      return (int'(idx) < width);
   endfunction

endpackage

// File: rtl/rev_gate_unit.sv
// rev_gate_unit -- combinational application of one reversible gate.
// Ports:
//   state      in   current WIDTH-bit register value
//   instr      in   decoded instruction (opcode + c1, c2, t indices)
//   next_state out  register value after the gate
//   conflict   out  instruction has aliased indices; it is applied as a NOP
// Build option: REV_SEQ_FREDKIN_EN enables opcode 11 as FREDKIN; without it
// opcode 11 is a NOP that never reports a conflict.
module rev_gate_unit
   import rev_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] state,
   input  instr_t           instr,
   output logic [WIDTH-1:0] next_state,
   output logic             conflict
);

   localparam int IW = $clog2(WIDTH);

   logic [IW-1:0] c1;
   logic [IW-1:0] c2;
   logic [IW-1:0] t;
   logic          in_range;

   assign c1 = instr.c1[IW-1:0];
   assign c2 = instr.c2[IW-1:0];
   assign t  = instr.t[IW-1:0];
   // Only matters for non power-of-two widths: unreachable bits leave state alone.
   assign in_range = idx_ok(instr.c1, WIDTH) && idx_ok(instr.c2, WIDTH) && idx_ok(instr.t, WIDTH);

   // Gate evaluation; aliased operands would make the gate non-reversible, so they are skipped.
   always_comb begin
      next_state = state;
      conflict   = 1'b0;
      case (instr.op)
         OP_CNOT: begin
            if (t == c1) begin
               conflict = 1'b1;
            end else if (in_range) begin
               next_state[t] = state[t] ^ state[c1];
            end else begin
               next_state = state;
            end
         end
         OP_TOFF: begin
            if ((t == c1) || (t == c2)) begin
               conflict = 1'b1;
            end else if (in_range) begin
               next_state[t] = state[t] ^ (state[c1] & state[c2]);
            end else begin
               next_state = state;
            end
         end
         OP_FRED: begin
`ifdef REV_SEQ_FREDKIN_EN
            if ((t == c1) || (c2 == c1)) begin
               conflict = 1'b1;
            end else if (in_range && state[c1]) begin
               next_state[c2] = state[t];
               next_state[t]  = state[c2];
            end else begin
               next_state = state;
            end
`else
            next_state = state;
`endif
         end
         default: begin
            next_state = state;
         end
      endcase
   end

endmodule

// File: rtl/rev_gate_sequencer.sv
// rev_gate_sequencer -- runs a stored program of reversible gates over a
// WIDTH-bit register, forward or in reverse (uncompute), one gate per cycle.
// Ports:
//   clk, rst            clock; synchronous active-high reset (clears memory to NOP)
//   prog_we/addr/data   program write port, honoured only in IDLE;
//                       data = {opcode[1:0], c1, c2, t}
//   start, dir, len     launch a run; dir 1 = reverse; len clamped to DEPTH
//   state_in            initial register value captured at start
//   state_out           register value, final while done is high, then held
//   busy                high while running
//   done                one-cycle completion pulse
//   err                 sticky: some instruction of the run had aliased indices
// Build option: REV_SEQ_FREDKIN_EN (see rev_gate_unit).
module rev_gate_sequencer
   import rev_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 prog_we,
   input  logic [$clog2(DEPTH)-1:0]             prog_addr,
   input  logic [2+3*$clog2(WIDTH)-1:0]         prog_data,
   input  logic                                 start,
   input  logic                                 dir,
   input  logic [$clog2(DEPTH):0]               len,
   input  logic [WIDTH-1:0]                     state_in,
   output logic [WIDTH-1:0]                     state_out,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err
);

   localparam int IW = $clog2(WIDTH);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = 2 + 3 * IW;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   fsm_t             fsm;
   fsm_t             fsm_nx;
   logic [AW-1:0]    pc;
   logic [AW-1:0]    pc_nx;
   logic [AW:0]      cnt;
   logic [AW:0]      cnt_nx;
   logic [AW:0]      len_c;
   logic             run_dir;
   logic             run_dir_nx;
   logic [WIDTH-1:0] state_nx;
   logic             err_nx;
   logic [DW-1:0]    mem [DEPTH];
   logic [DW-1:0]    raw;
   instr_t           instr;
   logic [WIDTH-1:0] gate_state;
   logic             gate_conflict;

   assign len_c = (len > DEPTH_L) ? DEPTH_L : len;

   // Combinational read so the next gate is ready in the cycle pc changes.
   assign raw   = mem[pc];
   assign instr = '{op: op_t'(raw[DW-1 -: 2]),
                    c1: MAX_IW'(raw[3*IW-1 -: IW]),
                    c2: MAX_IW'(raw[2*IW-1 -: IW]),
                    t:  MAX_IW'(raw[IW-1:0])};

   rev_gate_unit #(
      .WIDTH(WIDTH)
   ) u_gate (
      .state      (state_out),
      .instr      (instr),
      .next_state (gate_state),
      .conflict   (gate_conflict)
   );

   // Sequencer next-state: launch, step through len gates, pulse done.
   always_comb begin
      fsm_nx     = fsm;
      pc_nx      = pc;
      cnt_nx     = cnt;
      run_dir_nx = run_dir;
      state_nx   = state_out;
      err_nx     = err;
      case (fsm)
         ST_IDLE: begin
            if (start) begin
               state_nx   = state_in;
               err_nx     = 1'b0;
               run_dir_nx = dir;
               cnt_nx     = len_c;
               // Reverse runs begin at the last instruction of the program.
               pc_nx      = dir ? AW'(len_c - (AW+1)'(1)) : {AW{1'b0}};
               fsm_nx     = (len_c == {(AW+1){1'b0}}) ? ST_DONE : ST_RUN;
            end else begin
               fsm_nx = ST_IDLE;
            end
         end
         ST_RUN: begin
            state_nx = gate_state;
            err_nx   = err | gate_conflict;
            cnt_nx   = cnt - (AW+1)'(1);
            if (cnt == (AW+1)'(1)) begin
               fsm_nx = ST_DONE;
            end else begin
               fsm_nx = ST_RUN;
               pc_nx  = run_dir ? (pc - AW'(1)) : (pc + AW'(1));
            end
         end
         ST_DONE: begin
            fsm_nx = ST_IDLE;
         end
         default: begin
            fsm_nx = ST_IDLE;
         end
      endcase
   end

   // State and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= ST_IDLE;
         pc        <= {AW{1'b0}};
         cnt       <= {(AW+1){1'b0}};
         run_dir   <= 1'b0;
         state_out <= {WIDTH{1'b0}};
         err       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         fsm       <= fsm_nx;
         pc        <= pc_nx;
         cnt       <= cnt_nx;
         run_dir   <= run_dir_nx;
         state_out <= state_nx;
         err       <= err_nx;
         busy      <= (fsm_nx == ST_RUN);
         done      <= (fsm_nx == ST_DONE);
      end
   end

   // Program memory; all-zero words are NOPs, and writes are locked out while running.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {DW{1'b0}};
         end
      end else if (prog_we && (fsm == ST_IDLE)) begin
         mem[prog_addr] <= prog_data;
      end
   end

endmodule

// File: doc/rev_gate_sequencer.md
REV_GATE_SEQUENCER -- requirements
Module: rev_gate_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits in the reversible state register.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of program memory entries; IW = $clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port prog_we  input  1  writes prog_data to program memory at prog_addr.
REQ-006 SHALL have port prog_addr  input  $clog2(DEPTH)  the program write address.
REQ-007 SHALL have port prog_data  input  2+3*IW  the instruction {opcode[1:0], c1, c2, t}.
REQ-008 SHALL have port start  input  1  requests execution of the program.
REQ-009 SHALL have port dir  input  1  selects direction: 0 = forward, 1 = reverse (uncompute).
REQ-010 SHALL have port len  input  $clog2(DEPTH)+1  the instruction count; values above DEPTH are clamped to DEPTH.
REQ-011 SHALL have port state_in  input  WIDTH  the initial state register value.
REQ-012 SHALL have port state_out  output  WIDTH  the current state register value.
REQ-013 SHALL have port busy  output  1  which is high while in RUN.
REQ-014 SHALL have port done  output  1  a one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  a sticky flag indicating an index-conflict instruction.

Function
REQ-016 Opcodes SHALL be: 00 NOP; 01 CNOT (s[t] ^= s[c1]); 10 TOFFOLI (s[t] ^= s[c1] & s[c2]); 11 FREDKIN (if s[c1], swap s[c2] and s[t]).
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; IDLE goes to RUN on start when len != 0, and to DONE on start when len == 0.
REQ-018 On accepting start, the block SHALL capture state_in, dir and the clamped len, clear err, and set pc to 0 (forward) or len-1 (reverse).
REQ-019 In RUN the block SHALL execute exactly one instruction per cycle, stepping pc by +1 or -1 and moving to DONE after the len-th instruction.
REQ-020 done SHALL be high exactly during cycle len+1 after the start cycle; DONE then returns to IDLE.
REQ-021 state_out SHALL be valid while done is high and SHALL hold until the next accepted start.
REQ-022 start SHALL be ignored when in RUN or DONE; prog_we SHALL be ignored when not in IDLE.
REQ-023 Conflicts are: t==c1; TOFFOLI with t==c2; FREDKIN with c2==c1. A conflicting instruction SHALL act as NOP and set err.
REQ-024 Memory reads SHALL be combinational from pc, so there are no bubbles between instructions.

Reset
REQ-025 rst SHALL force IDLE, state_out=0, busy=0, done=0, err=0, pc=0, and all memory entries to NOP, aborting any run in progress.

Configuration
REQ-026 With REV_SEQ_FREDKIN_EN defined, opcode 11 SHALL execute FREDKIN; without it, opcode 11 SHALL execute as NOP and never set err.

Structure
REQ-027 Package rev_seq_pkg SHALL hold the opcode enum, the packed instruction struct, and the FSM state enum.
REQ-028 Single-instruction application SHALL be implemented in a combinational sub-module rev_gate_unit (inputs: state and instruction; outputs: next state and conflict).

Verification
REQ-029 Program CNOT c1=0,t=1 with len=1, forward; state_in 0x00/0x01/0x02/0x03 -> state_out 0x00/0x03/0x02/0x01, with done in cycle 2.
REQ-030 Program TOFF(0,1->2), CNOT(2->3), FRED(3; 4<->5) with len=3, forward, state_in 0x13 -> 0x2F; then reverse with state_in 0x2F -> 0x13.
REQ-031 Same program built without REV_SEQ_FREDKIN_EN, forward, state_in 0x13 -> 0x1F with err=0.
REQ-032 len=0, state_in 0xA5 -> done in cycle 1, state_out 0xA5; start pulsed during RUN has no effect.
REQ-033 Program CNOT c1=2,t=2, state_in 0x04 -> state_out 0x04, err=1; the next start clears err.
REQ-034 len=8 run with rst asserted in cycle 3 -> next cycle busy=0, done=0, state_out=0x00, and a rerun with len=8 leaves state_in unchanged (all entries NOP).
